// File: rtl/memory_responder.sv
// Memory-side responder for the CPU bus: fixed-latency reads and writes
// served from an internal word array, read data driven only during inputReady.
module memory_responder #(
  parameter int WORD_SIZE     = 16,
  parameter int DEPTH         = 256,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 readM,
  input  logic                 writeM,
  input  logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  output logic                 inputReady,
  output logic                 ackOutput,
  output logic                 busy
);

  localparam int AW   = $clog2(DEPTH);
  localparam int LMAX = (READ_LATENCY > WRITE_LATENCY) ?
                        READ_LATENCY : WRITE_LATENCY;
  localparam int CW   = $clog2(LMAX + 1);

  localparam logic [WORD_SIZE:0] DEPTH_W = (WORD_SIZE+1)'(DEPTH);
  localparam logic [CW-1:0] RD_LOAD = CW'(READ_LATENCY - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WRITE_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_RESP,
    WR_WAIT,
    WR_ACK
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        cnt_d;
  logic [WORD_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0] wdata_q;
  logic [WORD_SIZE-1:0] rdata_q;
  logic                 in_range;
  logic                 rd_load;
  logic                 wr_commit;
  logic                 drive_en;

  logic [WORD_SIZE-1:0] mem [DEPTH];

  assign in_range  = ({1'b0, addr_q} < DEPTH_W);
  assign rd_load   = (state_q == RD_WAIT) && (cnt_q == '0);
  assign wr_commit = reset_n && (state_q == WR_WAIT) &&
                     (cnt_q == '0) && in_range;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The wait states always last LATENCY edges, so even a latency
  // of one passes through a wait state before the pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (readM) begin
          state_d = RD_WAIT;
          cnt_d   = RD_LOAD;
        end else if (writeM) begin
          state_d = WR_WAIT;
          cnt_d   = WR_LOAD;
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) state_d = RD_RESP;
        else             cnt_d   = cnt_q - CW'(1);
      end
      WR_WAIT: begin
        if (cnt_q == '0) state_d = WR_ACK;
        else             cnt_d   = cnt_q - CW'(1);
      end
      RD_RESP: state_d = IDLE;
      WR_ACK:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    inputReady = (state_q == RD_RESP);
    ackOutput  = (state_q == WR_ACK);
    busy       = (state_q != IDLE);
    drive_en   = (state_q == RD_RESP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state_q == IDLE) begin
      if (readM || writeM) addr_q <= address;
      if (writeM && !readM) wdata_q <= data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else if (rd_load) begin
      rdata_q <= in_range ? mem[addr_q[AW-1:0]] : '0;
    end
  end

  // Array has no reset; contents survive reset_n.
  always_ff @(posedge clk) begin
    if (wr_commit) mem[addr_q[AW-1:0]] <= wdata_q;
  end

  assign data = drive_en ? rdata_q : {WORD_SIZE{1'bz}};

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: latency-2 instance for most scenarios,
// latency-1 instance for back-to-back reads. Pull-ups make a released bus read FFFF.
module tb_memory_responder;

  logic        clk;
  logic        reset_n;
  logic        readM;
  logic        writeM;
  logic [15:0] address;
  logic [15:0] drv;
  logic        drv_en;
  wire  [15:0] data0;
  wire  [15:0] data1;
  logic        ir0, ack0, busy0;
  logic        ir1, ack1, busy1;

  int errors = 0;
  int checks = 0;

  assign data0 = drv_en ? drv : 16'hzzzz;
  assign data1 = drv_en ? drv : 16'hzzzz;

  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (data0[i]);
    pullup (data1[i]);
  end

  memory_responder #(
    .WORD_SIZE(16), .DEPTH(256),
    .READ_LATENCY(2), .WRITE_LATENCY(2)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .readM(readM), .writeM(writeM),
    .address(address), .data(data0),
    .inputReady(ir0), .ackOutput(ack0), .busy(busy0)
  );

  memory_responder #(
    .WORD_SIZE(16), .DEPTH(256),
    .READ_LATENCY(1), .WRITE_LATENCY(1)
  ) dut1 (
    .clk(clk), .reset_n(reset_n),
    .readM(readM), .writeM(writeM),
    .address(address), .data(data1),
    .inputReady(ir1), .ackOutput(ack1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: one-cycle write, returns with both instances idle.
  task automatic do_write(input logic [15:0] a, input logic [15:0] v);
    writeM = 1'b1; address = a; drv = v; drv_en = 1'b1;
    step();
    writeM = 1'b0; drv_en = 1'b0;
    step(); step(); step();
  endtask

  // Stimulus only: returns sampled in the latency-2 pulse cycle.
  task automatic issue_read(input logic [15:0] a);
    readM = 1'b1; address = a;
    step();
    readM = 1'b0;
    step(); step();
  endtask

  task automatic test_reset();
    reset_n = 1'b1; readM = 1'b0; writeM = 1'b0;
    address = '0; drv = '0; drv_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({ir0, ack0, busy0} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outs: got %b expected 000", {ir0, ack0, busy0});
    end
    checks++;
    if (data0 !== 16'hFFFF) begin
      errors++;
      $display("FAIL reset_bus: got %h expected FFFF", data0);
    end
    step(); step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_write();
    logic exp_ack, exp_busy;
    writeM = 1'b1; address = 16'h0005; drv = 16'hBEEF; drv_en = 1'b1;
    step();
    writeM = 1'b0; drv_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      exp_ack  = (i == 2);
      exp_busy = (i <= 2);
      checks++;
      if (ack0 !== exp_ack || busy0 !== exp_busy) begin
        errors++;
        $display("FAIL write_c%0d: ack=%b busy=%b expected ack=%b busy=%b",
                 i, ack0, busy0, exp_ack, exp_busy);
      end
    end
  endtask

  task automatic test_read();
    logic        exp_ir;
    logic [15:0] exp_d;
    readM = 1'b1; address = 16'h0005;
    #1;
    checks++;
    if (data0 !== 16'hFFFF) begin
      errors++;
      $display("FAIL read_prebus: got %h expected FFFF", data0);
    end
    step();
    readM = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      exp_ir = (i == 2);
      exp_d  = (i == 2) ? 16'hBEEF : 16'hFFFF;
      checks++;
      if (ir0 !== exp_ir || data0 !== exp_d) begin
        errors++;
        $display("FAIL read_c%0d: ir=%b data=%h expected ir=%b data=%h",
                 i, ir0, data0, exp_ir, exp_d);
      end
    end
  endtask

  task automatic test_rw_conflict();
    int acks = 0;
    readM = 1'b1; writeM = 1'b1; address = 16'h0005;
    drv = 16'h1234; drv_en = 1'b1;
    step();
    readM = 1'b0; writeM = 1'b0; drv_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      if (ack0) acks++;
      if (i == 2) begin
        checks++;
        if (ir0 !== 1'b1 || data0 !== 16'hBEEF) begin
          errors++;
          $display("FAIL rw_read: ir=%b data=%h expected ir=1 data=BEEF",
                   ir0, data0);
        end
      end
    end
    checks++;
    if (acks != 0) begin
      errors++;
      $display("FAIL rw_noack: got %0d acks expected 0", acks);
    end
    issue_read(16'h0005);
    checks++;
    if (data0 !== 16'hBEEF) begin
      errors++;
      $display("FAIL rw_reread: got %h expected BEEF", data0);
    end
    step();
  endtask

  task automatic test_out_of_range();
    do_write(16'h0000, 16'h5A5A);
    issue_read(16'h0100);
    checks++;
    if (ir0 !== 1'b1 || data0 !== 16'h0000) begin
      errors++;
      $display("FAIL oor_read: ir=%b data=%h expected ir=1 data=0000",
               ir0, data0);
    end
    step();
    writeM = 1'b1; address = 16'h0100; drv = 16'hAAAA; drv_en = 1'b1;
    step();
    writeM = 1'b0; drv_en = 1'b0;
    step(); step();
    checks++;
    if (ack0 !== 1'b1) begin
      errors++;
      $display("FAIL oor_ack: got %b expected 1", ack0);
    end
    step();
    issue_read(16'h0000);
    checks++;
    if (data0 !== 16'h5A5A) begin
      errors++;
      $display("FAIL oor_alias: got %h expected 5A5A", data0);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int acks = 0;
    do_write(16'h0003, 16'h1111);
    writeM = 1'b1; address = 16'h0003; drv = 16'h7777; drv_en = 1'b1;
    step();
    writeM = 1'b0; drv_en = 1'b0;
    step();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({ir0, ack0, busy0} !== 3'b000 || data0 !== 16'hFFFF) begin
      errors++;
      $display("FAIL midrst_outs: outs=%b data=%h expected 000 FFFF",
               {ir0, ack0, busy0}, data0);
    end
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (ack0) acks++;
    end
    checks++;
    if (acks != 0) begin
      errors++;
      $display("FAIL midrst_noack: got %0d acks expected 0", acks);
    end
    issue_read(16'h0003);
    checks++;
    if (data0 !== 16'h1111) begin
      errors++;
      $display("FAIL midrst_keep: got %h expected 1111", data0);
    end
    step();
  endtask

  task automatic test_back_to_back();
    do_write(16'h0006, 16'h6666);
    readM = 1'b1; address = 16'h0005;
    step();
    checks++;
    if (ir1 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_wait1: got %b expected 0", ir1);
    end
    step();
    readM = 1'b0;
    checks++;
    if (ir1 !== 1'b1 || data1 !== 16'hBEEF) begin
      errors++;
      $display("FAIL b2b_first: ir=%b data=%h expected ir=1 data=BEEF",
               ir1, data1);
    end
    step();
    readM = 1'b1; address = 16'h0006;
    checks++;
    if (ir1 !== 1'b0 || data1 !== 16'hFFFF) begin
      errors++;
      $display("FAIL b2b_gap: ir=%b data=%h expected ir=0 data=FFFF",
               ir1, data1);
    end
    step();
    checks++;
    if (ir1 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_wait2: got %b expected 0", ir1);
    end
    step();
    readM = 1'b0;
    checks++;
    if (ir1 !== 1'b1 || data1 !== 16'h6666) begin
      errors++;
      $display("FAIL b2b_second: ir=%b data=%h expected ir=1 data=6666",
               ir1, data1);
    end
    step();
    checks++;
    if (ir1 !== 1'b0 || data1 !== 16'hFFFF) begin
      errors++;
      $display("FAIL b2b_end: ir=%b data=%h expected ir=0 data=FFFF",
               ir1, data1);
    end
    step(); step();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_rw_conflict();
    test_out_of_range();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
